ycbcr_color_box: RTL

Sits directly downstream of the RGB-to-YCbCr converter. It consumes the YCbCr stream and its hsync, vsync and de timing.
- Per pixel: marks a pixel as a fruit pixel when its Cb and Cr both fall inside programmable windows, and emits a binary mask video stream.
- Per frame: accumulates the bounding box and hit count of the marked pixels, and publishes them once at each frame boundary for the downstream recognition logic.

---
 rtl/isp_pkg.sv | 16 +
 rtl/ycbcr_color_box_box_accum.sv | 135 +++++++++++++
 rtl/ycbcr_color_box.sv | 89 ++++++++
 3 files changed

// File: rtl/isp_pkg.sv
// Shared definitions for the colour-box pixel pipeline: default widths,
// accumulator state encoding and the mask video levels.
package isp_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int PIX_W_DEF = 22;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACCUM   = 1'b1
  } box_state_t;

  localparam logic [23:0] MASK_ON  = 24'hFFFFFF;
  localparam logic [23:0] MASK_OFF = 24'h000000;

endpackage

// File: rtl/ycbcr_color_box_box_accum.sv
// Coordinate counters, per-frame bounding box / hit-count accumulators and
// the result latch that publishes them at each frame edge.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// WAIT_VS | after reset; accumulators held clear until the first frame edge
// ACCUM   | hits update the box; every frame edge publishes and re-clears
module box_accum
  import isp_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int MIN_PIX = 64
) (
  input  logic             pixelclk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             de,
  input  logic             frame_edge,
  output logic [CNT_W-1:0] o_x_min,
  output logic [CNT_W-1:0] o_x_max,
  output logic [CNT_W-1:0] o_y_min,
  output logic [CNT_W-1:0] o_y_max,
  output logic [PIX_W-1:0] o_pix_cnt,
  output logic             o_valid,
  output logic             o_frame_done
);

  box_state_t       state, state_nxt;
  logic             acc_en, publish;
  logic             de_d, de_fall;
  logic [CNT_W-1:0] x_cnt, y_cnt;
  logic [CNT_W-1:0] x_min_a, x_max_a, y_min_a, y_max_a;
  logic [PIX_W-1:0] pix_a;

  assign de_fall = de_d & ~de;

  // Pixel coordinates: x restarts every line, y counts line ends; both saturate.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      de_d  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      de_d <= de;
      if (frame_edge) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else begin
        if (de) begin
          if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
        end else if (de_fall) begin
          x_cnt <= '0;
        end
        if (de_fall && (y_cnt != '1)) y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  // Next state: the first frame edge after reset starts accumulation.
  always_comb begin
    state_nxt = state;
    if ((state == WAIT_VS) && frame_edge) state_nxt = ACCUM;
  end

  // Control decode: a frame edge wins over a coincident hit.
  always_comb begin
    acc_en  = 1'b0;
    publish = 1'b0;
    if (state == ACCUM) begin
      publish = frame_edge;
      acc_en  = hit & ~frame_edge;
    end
  end

  // Running box and count for the frame in progress.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      x_min_a <= '0;
      x_max_a <= '0;
      y_min_a <= '0;
      y_max_a <= '0;
      pix_a   <= '0;
    end else if (publish || (state == WAIT_VS)) begin
      x_min_a <= '1;
      x_max_a <= '0;
      y_min_a <= '1;
      y_max_a <= '0;
      pix_a   <= '0;
    end else if (acc_en) begin
      if (x_cnt < x_min_a) x_min_a <= x_cnt;
      if (x_cnt > x_max_a) x_max_a <= x_cnt;
      if (y_cnt < y_min_a) y_min_a <= y_cnt;
      if (y_cnt > y_max_a) y_max_a <= y_cnt;
      if (pix_a != '1)     pix_a   <= pix_a + 1'b1;
    end
  end

  // Result latch; an empty frame reports an all-zero box instead of the clear values.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_pix_cnt    <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= publish;
      if (publish) begin
        o_pix_cnt <= pix_a;
        o_valid   <= (pix_a >= PIX_W'(MIN_PIX));
        if (pix_a == '0) begin
          o_x_min <= '0;
          o_x_max <= '0;
          o_y_min <= '0;
          o_y_max <= '0;
        end else begin
          o_x_min <= x_min_a;
          o_x_max <= x_max_a;
          o_y_min <= y_min_a;
          o_y_max <= y_max_a;
        end
      end
    end
  end

endmodule

// File: rtl/ycbcr_color_box.sv
// Chroma-window fruit detector: binary mask video plus per-frame bounding box.
module ycbcr_color_box
  import isp_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int MIN_PIX = 64,
  parameter bit VS_POL  = 1'b1
) (
  input  logic             pixelclk,
  input  logic             rst_n,
  input  logic [23:0]      i_ycbcr,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  input  logic [7:0]       i_cb_min,
  input  logic [7:0]       i_cb_max,
  input  logic [7:0]       i_cr_min,
  input  logic [7:0]       i_cr_max,
  output logic [23:0]      o_bin,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x_min,
  output logic [CNT_W-1:0] o_x_max,
  output logic [CNT_W-1:0] o_y_min,
  output logic [CNT_W-1:0] o_y_max,
  output logic [PIX_W-1:0] o_pix_cnt,
  output logic             o_valid,
  output logic             o_frame_done
);

  logic [7:0] cb, cr;
  logic       hit, vs_act, vs_act_d, frame_edge;
  logic       unused_y;

  assign cb       = i_ycbcr[15:8];
  assign cr       = i_ycbcr[7:0];
  // Luma plays no part in the chroma window.
  assign unused_y = ^i_ycbcr[23:16];

  // An inverted window (min > max) can never satisfy both compares, so no hit.
  assign hit = i_de & (cb >= i_cb_min) & (cb <= i_cb_max)
                    & (cr >= i_cr_min) & (cr <= i_cr_max);

  assign vs_act     = (i_vsync == VS_POL);
  assign frame_edge = vs_act & ~vs_act_d;

  // Remember the previous vsync activity for edge detection.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) vs_act_d <= 1'b0;
    else        vs_act_d <= vs_act;
  end

  // Mask video and timing, all delayed one cycle together.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      o_bin   <= MASK_OFF;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_de    <= 1'b0;
    end else begin
      o_bin   <= hit ? MASK_ON : MASK_OFF;
      o_hsync <= i_hsync;
      o_vsync <= i_vsync;
      o_de    <= i_de;
    end
  end

  box_accum #(
    .CNT_W   (CNT_W),
    .PIX_W   (PIX_W),
    .MIN_PIX (MIN_PIX)
  ) u_box_accum (
    .pixelclk     (pixelclk),
    .rst_n        (rst_n),
    .hit          (hit),
    .de           (i_de),
    .frame_edge   (frame_edge),
    .o_x_min      (o_x_min),
    .o_x_max      (o_x_max),
    .o_y_min      (o_y_min),
    .o_y_max      (o_y_max),
    .o_pix_cnt    (o_pix_cnt),
    .o_valid      (o_valid),
    .o_frame_done (o_frame_done)
  );

endmodule
